// File: rtl/seq_divider.sv
// Sequential restoring divider: DW-bit dividend / VW-bit divisor, one quotient
// bit per clock, with a start/busy/done handshake and a divide-by-zero path.
module seq_divider #(
  parameter int DW = 6,
  parameter int VW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quot,
  output logic [VW-1:0] rem,
  output logic          div_zero
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, CALC, ZERO} state_t;

  state_t        state;
  logic [DW-1:0] shreg, shreg_nx;
  logic [VW:0]   prem, prem_sh, prem_nx;
  logic [VW-1:0] dvs;
  logic [CW-1:0] cnt;
  logic          ge;

  // One restoring step: the partial remainder stays below the divisor, so
  // dropping its top bit before the shift loses nothing.
  always_comb begin
    prem_sh  = {prem[VW-1:0], shreg[DW-1]};
    ge       = (prem_sh >= {1'b0, dvs});
    prem_nx  = ge ? (prem_sh - {1'b0, dvs}) : prem_sh;
    shreg_nx = {shreg[DW-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      prem     <= '0;
      dvs      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quot     <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (divisor == '0) begin
              state <= ZERO;
            end else begin
              shreg <= dividend;
              dvs   <= divisor;
              prem  <= '0;
              cnt   <= CW'(DW - 1);
              state <= CALC;
            end
          end
        end
        CALC: begin
          shreg <= shreg_nx;
          prem  <= prem_nx;
          if (cnt == '0) begin
            quot     <= shreg_nx;
            rem      <= prem_nx[VW-1:0];
            div_zero <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ZERO: begin
          quot     <= '1;
          rem      <= '0;
          div_zero <= 1'b1;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and shuffled-exhaustive checks of seq_divider against plain
// integer division, including latency, handshake and reset abort.
module tb_seq_divider;
  localparam int DW = 6;
  localparam int VW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          busy, done, div_zero;
  logic [DW-1:0] quot;
  logic [VW-1:0] rem;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  seq_divider #(.DW(DW), .VW(VW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend),
    .divisor(divisor), .busy(busy), .done(done), .quot(quot), .rem(rem),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present operands at a negedge; the following posedge is E0. Returns at
  // the negedge after E0.
  task automatic launch(input int a, input int b);
    start    = 1'b1;
    dividend = DW'(a);
    divisor  = VW'(b);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges after E0 until done; busy must be high until then.
  task automatic wait_done(input int l0, output int lat);
    lat = l0;
    while (done !== 1'b1 && lat < 20) begin
      chk("busy_during_op", int'(busy), 1);
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) chk("done_timeout", lat, -1);
  endtask

  // Expected results from plain integer arithmetic.
  task automatic check_result(input string tag, input int a, input int b, input int lat);
    int eq, er;
    if (b == 0) begin
      eq = (1 << DW) - 1; er = 0;
    end else begin
      eq = a / b; er = a % b;
    end
    chk({tag, "_latency"}, lat, (b == 0) ? 1 : DW);
    chk({tag, "_quot"}, int'(quot), eq);
    chk({tag, "_rem"}, int'(rem), er);
    chk({tag, "_divzero"}, int'(div_zero), (b == 0) ? 1 : 0);
    chk({tag, "_busy_at_done"}, int'(busy), 0);
    if (b != 0) begin
      chk({tag, "_invariant"}, int'(quot) * b + int'(rem), a);
      chk({tag, "_rem_lt_div"}, int'(int'(rem) < b), 1);
    end
  endtask

  task automatic run_one(input string tag, input int a, input int b);
    int lat;
    launch(a, b);
    wait_done(0, lat);
    check_result(tag, a, b, lat);
    @(negedge clk);
    chk({tag, "_done_single"}, int'(done), 0);
  endtask

  int lat, dc0;
  int order[64*8];

  initial begin
    // Reset state
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quot", int'(quot), 0);
    chk("rst_rem", int'(rem), 0);
    chk("rst_divzero", int'(div_zero), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_one("d49_7", 49, 7);
    run_one("d35_6", 35, 6);
    run_one("d5_7", 5, 7);
    run_one("d63_1", 63, 1);
    run_one("d42_0", 42, 0);
    run_one("d12_4", 12, 4);

    // start while busy is ignored
    dc0 = done_cnt;
    launch(60, 4);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 6'd9; divisor = 3'd3;
    @(negedge clk);
    start = 1'b0; dividend = 6'd17; divisor = 3'd5;
    wait_done(3, lat);
    check_result("busy_ignore", 60, 4, lat);
    repeat (10) @(negedge clk);
    chk("busy_ignore_one_done", done_cnt - dc0, 1);

    // Back-to-back: start accepted in the done cycle
    launch(49, 7);
    wait_done(0, lat);
    check_result("b2b_first", 49, 7, lat);
    launch(48, 5);
    chk("b2b_hold_quot", int'(quot), 7);
    chk("b2b_hold_rem", int'(rem), 0);
    wait_done(0, lat);
    check_result("b2b_second", 48, 5, lat);
    @(negedge clk);

    // Reset mid-CALC aborts with no done
    dc0 = done_cnt;
    launch(63, 2);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_quot", int'(quot), 0);
    chk("abort_rem", int'(rem), 0);
    chk("abort_divzero", int'(div_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_done", done_cnt - dc0, 0);
    run_one("after_abort", 63, 2);

    // Every operand pair, in shuffled order
    for (int i = 0; i < 64*8; i++) order[i] = i;
    for (int i = 64*8 - 1; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(i, 0));
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 64*8; i++)
      run_one("sweep", order[i] >> 3, order[i] & 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
